// File: rtl/alu_issue_pipe.sv
// Two-stage valid/ready issue front-end for a small 2-bit operand ALU.
// Stage 1 latches the command; stage 2 holds the registered result.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   command handshake (a, b, op, tag)
//   out_valid/out_ready result handshake (result, rem, err, tag)
//   err_sticky          set by any errored result handshake
//   op_count            completed handshakes, wrapping
//   err_count           errored handshakes, saturating
//   clr_status          sync clear of the status fields (beats a handshake)
module alu_issue_pipe #(
    parameter int TAG_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic [1:0]       out_rem,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_sticky,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_status
);

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_a_q, s1_b_q;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q, s2_valid_d;
    logic [3:0]       s2_res_q;
    logic [1:0]       s2_rem_q;
    logic             s2_err_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] opc_q, opc_d;
    logic [CNT_W-1:0] errc_q, errc_d;

    logic       s2_load, in_hs, out_hs;
    logic [3:0] a4, b4;
    logic [3:0] alu_res;
    logic [1:0] alu_rem;
    logic       alu_err;

    // Stage 2 may refill in the same cycle it drains, so in_ready
    // depends combinationally on out_ready.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = s2_valid_q && out_ready;

    assign a4 = {2'b00, s1_a_q};
    assign b4 = {2'b00, s1_b_q};

    always_comb begin
        alu_res = 4'd0;
        alu_rem = 2'd0;
        alu_err = 1'b0;
        unique case (s1_op_q)
            3'b000: alu_res = a4 + b4;
            3'b001: alu_res = a4 - b4;
            3'b010: alu_res = a4 & b4;
            3'b011: alu_res = a4 | b4;
            3'b100: alu_res = a4 * b4;
            3'b101, 3'b110: begin
                // Divide-by-zero returns the dividend as remainder.
                if (s1_b_q == 2'd0) begin
                    alu_rem = s1_a_q;
                    alu_err = 1'b1;
                end else begin
                    alu_rem = s1_a_q % s1_b_q;
                    if (s1_op_q == 3'b101)
                        alu_res = {2'b00, s1_a_q / s1_b_q};
                    else
                        alu_res = {2'b00, s1_a_q % s1_b_q};
                end
            end
            3'b111: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_hs)
            s1_valid_d = 1'b1;
        else if (s2_load)
            s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        if (s2_load)
            s2_valid_d = 1'b1;
        else if (out_hs)
            s2_valid_d = 1'b0;
    end

    always_comb begin
        sticky_d = sticky_q;
        opc_d    = opc_q;
        errc_d   = errc_q;
        if (clr_status) begin
            sticky_d = 1'b0;
            opc_d    = '0;
            errc_d   = '0;
        end else if (out_hs) begin
            opc_d = opc_q + CNT_W'(1);
            if (s2_err_q) begin
                sticky_d = 1'b1;
                if (errc_q != '1)
                    errc_d = errc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_rem_q   <= '0;
            s2_err_q   <= 1'b0;
            s2_tag_q   <= '0;
            sticky_q   <= 1'b0;
            opc_q      <= '0;
            errc_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sticky_q   <= sticky_d;
            opc_q      <= opc_d;
            errc_q     <= errc_d;
            if (in_hs) begin
                s1_a_q   <= in_a;
                s1_b_q   <= in_b;
                s1_op_q  <= in_op;
                s1_tag_q <= in_tag;
            end
            if (s2_load) begin
                s2_res_q <= alu_res;
                s2_rem_q <= alu_rem;
                s2_err_q <= alu_err;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_res_q;
    assign out_rem    = s2_rem_q;
    assign out_err    = s2_err_q;
    assign out_tag    = s2_tag_q;
    assign err_sticky = sticky_q;
    assign op_count   = opc_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Self-checking bench for alu_issue_pipe: directed vector table,
// multi-cycle corner sequences and a randomized scoreboard run.
module tb_alu_issue_pipe;

    localparam int TAG_W = 2;
    localparam int CNT_W = 8;

    logic             clk, rst_n;
    logic             in_valid, in_ready;
    logic [1:0]       in_a, in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [3:0]       out_result;
    logic [1:0]       out_rem;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;
    logic             err_sticky;
    logic [CNT_W-1:0] op_count, err_count;
    logic             clr_status;

    alu_issue_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rem(out_rem),
        .out_err(out_err), .out_tag(out_tag),
        .err_sticky(err_sticky), .op_count(op_count),
        .err_count(err_count), .clr_status(clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int a, b, op, tag;
        int res, rem, err;
    } vec_t;

    typedef struct {
        int res, rem, err, tag;
        int acc;
    } item_t;

    // Reference model straight from the op table.
    function automatic item_t ref_op(int a, int b, int op, int tag);
        item_t r;
        r.res = 0; r.rem = 0; r.err = 0; r.tag = tag; r.acc = 0;
        case (op)
            0: r.res = (a + b) % 16;
            1: r.res = (a - b + 16) % 16;
            2: r.res = a & b;
            3: r.res = a | b;
            4: r.res = a * b;
            5, 6: begin
                if (b == 0) begin
                    r.rem = a; r.err = 1;
                end else begin
                    r.rem = a % b;
                    r.res = (op == 5) ? a / b : a % b;
                end
            end
            default: r.err = 1;
        endcase
        return r;
    endfunction

    int m_ops, m_errs, m_sticky;

    task automatic model_hs(input int err);
        m_ops = (m_ops + 1) % 256;
        if (err != 0) begin
            m_sticky = 1;
            if (m_errs < 255) m_errs++;
        end
    endtask

    task automatic chk_status(input string nm);
        chk({nm, ".op_count"}, op_count, m_ops);
        chk({nm, ".err_count"}, err_count, m_errs);
        chk({nm, ".err_sticky"}, err_sticky, m_sticky);
    endtask

    task automatic drive(input int a, input int b, input int op,
                         input int tag);
        in_valid = 1'b1;
        in_a = a[1:0]; in_b = b[1:0];
        in_op = op[2:0]; in_tag = tag[TAG_W-1:0];
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t  vt[12];
    item_t q[$];
    item_t e;

    initial begin
        vt[0]  = '{3, 2, 0, 1, 5, 0, 0};
        vt[1]  = '{1, 2, 1, 2, 15, 0, 0};
        vt[2]  = '{3, 3, 4, 3, 9, 0, 0};
        vt[3]  = '{3, 1, 2, 0, 1, 0, 0};
        vt[4]  = '{2, 1, 3, 1, 3, 0, 0};
        vt[5]  = '{3, 2, 5, 2, 1, 1, 0};
        vt[6]  = '{3, 2, 6, 3, 1, 1, 0};
        vt[7]  = '{2, 0, 5, 0, 0, 2, 1};
        vt[8]  = '{3, 0, 6, 1, 0, 3, 1};
        vt[9]  = '{3, 3, 7, 2, 0, 0, 1};
        vt[10] = '{0, 3, 1, 3, 13, 0, 0};
        vt[11] = '{3, 3, 0, 0, 6, 0, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_op = '0; in_tag = '0; out_ready = 1'b0; clr_status = 1'b0;
        m_ops = 0; m_errs = 0; m_sticky = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_result", out_result, 0);
        chk("reset.out_err", out_err, 0);
        chk_status("reset");

        // Directed table: one command at a time, latency checked.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
            out_ready = 1'b0;
            #1 chk("vec.in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("vec.latency", out_valid, 0);
            @(negedge clk);
            #1;
            chk("vec.out_valid", out_valid, 1);
            chk("vec.result", out_result, vt[i].res);
            chk("vec.rem", out_rem, vt[i].rem);
            chk("vec.err", out_err, vt[i].err);
            chk("vec.tag", out_tag, vt[i].tag);
            out_ready = 1'b1;
            model_hs(vt[i].err);
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            chk("vec.drained", out_valid, 0);
            chk_status("vec");
        end

        // Clear with no handshake in flight.
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        m_ops = 0; m_errs = 0; m_sticky = 0;
        #1 chk_status("clr");

        // Back-pressure: three offered, two accepted, then drain.
        @(negedge clk);
        drive(1, 1, 0, 0);
        #1 chk("bp.rdy0", in_ready, 1);
        @(negedge clk);
        drive(2, 1, 1, 1);
        #1 chk("bp.rdy1", in_ready, 1);
        @(negedge clk);
        drive(3, 2, 4, 2);
        #1;
        chk("bp.full", in_ready, 0);
        chk("bp.hold.res0", out_result, 2);
        chk("bp.hold.tag0", out_tag, 0);
        @(negedge clk);
        #1;
        chk("bp.still_full", in_ready, 0);
        chk("bp.stable.res", out_result, 2);
        chk("bp.stable.tag", out_tag, 0);
        chk("bp.stable.valid", out_valid, 1);
        out_ready = 1'b1;
        #1 chk("bp.rdy_comb", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp.drain.tag1", out_tag, 1);
        chk("bp.drain.res1", out_result, 1);
        @(negedge clk);
        #1;
        chk("bp.drain.tag2", out_tag, 2);
        chk("bp.drain.res2", out_result, 6);
        chk("bp.drain.valid2", out_valid, 1);
        @(negedge clk);
        #1;
        chk("bp.empty", out_valid, 0);
        chk("bp.op_count", op_count, 3);

        // Saturation: 256 errored completions at full throughput.
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(i % 4, i % 4, 7, i % 4);
            #1 chk("sat.in_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("sat.op_wrap", op_count, 0);
        chk("sat.err_count", err_count, 255);
        chk("sat.sticky", err_sticky, 1);
        @(negedge clk);
        drive(1, 0, 5, 3);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("sat.op_after", op_count, 1);
        chk("sat.err_held", err_count, 255);

        // clr_status in a handshake cycle wins.
        out_ready = 1'b0;
        drive(1, 1, 0, 2);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("clrhs.valid", out_valid, 1);
        out_ready = 1'b1;
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("clrhs.op_count", op_count, 0);
        chk("clrhs.err_count", err_count, 0);
        chk("clrhs.sticky", err_sticky, 0);
        chk("clrhs.consumed", out_valid, 0);

        // Async reset with both stages full.
        @(negedge clk);
        drive(3, 3, 4, 1);
        @(negedge clk);
        drive(2, 2, 0, 2);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("arst.full", in_ready, 0);
        chk("arst.pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.in_ready", in_ready, 1);
        chk("arst.result", out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("arst.no_stale", out_valid, 0);
        end
        m_ops = 0; m_errs = 0; m_sticky = 0;
        chk_status("arst");

        // Randomized run against the queue model.
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit exp_valid, exp_rdy, ihs, ohs;
            int a, b, op, tg;
            @(negedge clk);
            a = $urandom_range(3); b = $urandom_range(3);
            op = $urandom_range(7); tg = $urandom_range(3);
            drive(a, b, op, tg);
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            clr_status = ($urandom_range(60) == 0);
            #1;
            // Head becomes visible one edge after acceptance.
            exp_valid = (q.size() > 0) && (cyc > q[0].acc + 1);
            exp_rdy = (q.size() < 2) || out_ready;
            chk("rnd.out_valid", out_valid, exp_valid);
            chk("rnd.in_ready", in_ready, exp_rdy);
            if (exp_valid) begin
                chk("rnd.result", out_result, q[0].res);
                chk("rnd.rem", out_rem, q[0].rem);
                chk("rnd.err", out_err, q[0].err);
                chk("rnd.tag", out_tag, q[0].tag);
            end
            chk_status("rnd");
            ihs = in_valid && exp_rdy;
            ohs = exp_valid && out_ready;
            if (clr_status) begin
                m_ops = 0; m_errs = 0; m_sticky = 0;
            end else if (ohs) begin
                model_hs(q[0].err);
            end
            if (ohs) void'(q.pop_front());
            if (ihs) begin
                e = ref_op(a, b, op, tg);
                e.acc = cyc;
                q.push_back(e);
            end
        end
        in_valid = 1'b0;
        clr_status = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
